if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller that sequences the PC register against a single-outstanding instruction-memory port with valid/ready handshakes. It holds the fetch PC, issues one read at a time, buffers the returned instruction until decode accepts it, and applies exception and branch/jump redirects. Any response that was in flight when a redirect arrived is discarded. It sits between the execute/CSR redirect logic and the decode stage, replacing the free-running PC update.

## Interface
- No parameters. Widths come from `defines.v`: `REG_BUS` = 64 bits, `EXCP_BUS`, `EXCP_INST_MISAL`, `PC_START`.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- excp_jmp_ena  in  1  exception/trap redirect request (highest priority)
- excp_pc  in  64  exception redirect target
- bj_ena  in  1  branch/jump redirect request
- new_pc  in  64  branch/jump target
- mem_req_valid  out  1  fetch request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  64  fetch address
- mem_rsp_valid  in  1  response data valid; never earlier than the cycle after acceptance
- mem_rsp_data  in  32  instruction word
- inst_valid  out  1  held instruction valid to decode
- id_ready  in  1  decode accepts instruction
- inst_pc  out  64  PC of held instruction
- inst  out  32  held instruction
- if_excp  out  `EXCP_BUS`  exception flags of held instruction; only `EXCP_INST_MISAL` is ever set

## Operation
- Clock and reset are fixed: one clock, `clk`; reset `rst` is synchronous and active-high.
- States:
  - IDLE: after reset.
  - REQ: request driven.
  - WAIT: accepted, awaiting response.
  - HOLD: instruction presented to decode.
  - DROP: discard one stale response.
- Fetch PC register `fpc`; `mem_req_addr = fpc`.
- Redirect priority: `excp_jmp_ena` over `bj_ena`. `redir = excp_jmp_ena | bj_ena`. `tgt = excp_jmp_ena ? excp_pc : new_pc`.
- IDLE -> REQ unconditionally.
- REQ:
  - `mem_req_valid=1`.
  - If redir and no handshake: `fpc<=tgt`, stay REQ. The request address may change before acceptance.
  - If handshake and no redir: -> WAIT.
  - If handshake and redir: `fpc<=tgt`, -> DROP.
- WAIT:
  - On `mem_rsp_valid` without redir: latch `inst<=mem_rsp_data`, `inst_pc<=fpc`, -> HOLD.
  - Redir without rsp: `fpc<=tgt`, -> DROP.
  - Redir with rsp in the same cycle: discard rsp, `fpc<=tgt`, -> REQ.
- DROP:
  - On `mem_rsp_valid`: discard, -> REQ.
  - Redir (with or without rsp): `fpc<=tgt`. If rsp arrived, -> REQ; otherwise stay DROP.
- HOLD:
  - `inst_valid=1`.
  - If `id_ready` without redir: `fpc<=fpc+4`, -> REQ.
  - If redir (regardless of `id_ready`): `inst_valid` drops next cycle, `fpc<=tgt`, -> REQ. Decode flushes on the same redirect signals, so a same-cycle acceptance is void.
- PC arithmetic: 64-bit, wraps modulo 2^64 with no flag.
- `mem_rsp_valid` in IDLE, REQ or HOLD is a protocol violation and is ignored.

## Timing
- Reset values:
  - state=IDLE, `fpc=PC_START`.
  - `mem_req_valid=0`, `inst_valid=0`.
  - `inst=0`, `inst_pc=0`, `if_excp=0`.
- First request: `mem_req_valid` high the first cycle after `rst` deasserts.
- All outputs are registered; no combinational path from any input to any output.
- Latency: request accepted in cycle N, response in N+k (k≥1) -> `inst_valid` high in N+k+1.
- Best-case throughput: one instruction per 3 cycles with `id_ready` held high.
- A redirect applied in cycle N produces a request to `tgt` in cycle N+1, except from WAIT/DROP, where it waits for the stale response.
- Reset mid-operation: any state returns to IDLE next cycle. An outstanding response arriving after reset lands in IDLE or REQ and is ignored; the memory side is reset together with this block.

## Configuration
- `IF_MISAL_EXCP_EN` defined:
  - In REQ, if `fpc[1:0]!=0`, no request is issued (`mem_req_valid=0`).
  - Next cycle -> HOLD with `inst=32'h00000013`, `inst_pc=fpc`, `if_excp[EXCP_INST_MISAL]=1`.
  - Redirect handling in HOLD is unchanged.
- `IF_MISAL_EXCP_EN` undefined: misaligned addresses are requested as-is and `if_excp` is constant 0.

## Test plan
- Reset release, memory ready and responding in 1 cycle, `id_ready=1` -> `mem_req_addr` sequence `PC_START`, `PC_START+4`, `PC_START+8`. `inst_valid` pulses every 3rd cycle with the matching `inst_pc`.
- `id_ready=0` for 5 cycles in HOLD -> `inst`/`inst_pc` stable, no new request. `id_ready=1` -> next request at `inst_pc+4`.
- `bj_ena` with `new_pc=0x80000100` in WAIT, response 3 cycles later -> response discarded, `inst_valid` stays 0, next request address `0x80000100`.
- `excp_jmp_ena` (`excp_pc=0x80000200`) and `bj_ena` (`new_pc=0x80000300`) in the same cycle in HOLD -> `inst_valid` low next cycle, request to `0x80000200`.
- `mem_req_ready=0` with a redirect in REQ -> `mem_req_addr` switches to the target next cycle; one accepted request, no DROP.
- With `IF_MISAL_EXCP_EN`, `bj_ena` to `0x80000102` -> no `mem_req_valid`, HOLD with `inst=0x00000013` and `if_excp[EXCP_INST_MISAL]=1`.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: fetch PC sequencer with one outstanding imem read.
// Optional misaligned-fetch trap: define IF_MISAL_EXCP_EN.
//
// Ports:
//   clk, rst          clock, sync active-high reset
//   excp_jmp_ena/pc   trap redirect (wins over branch)
//   bj_ena/new_pc     branch/jump redirect
//   mem_req_*         imem request (valid/ready, addr)
//   mem_rsp_*         imem response (valid, 32b data)
//   inst_valid/inst   held instruction to decode
//   inst_pc/if_excp   its PC and exception flags
//   id_ready          decode accepts held instruction

`ifndef REG_BUS
`define REG_BUS 63:0
`endif
`ifndef EXCP_BUS
`define EXCP_BUS 3:0
`endif
`ifndef EXCP_INST_MISAL
`define EXCP_INST_MISAL 0
`endif
`ifndef PC_START
`define PC_START 64'h0000_0000_8000_0000
`endif

module if_fetch_ctrl (
  input  logic            clk,
  input  logic            rst,
  input  logic            excp_jmp_ena,
  input  logic [`REG_BUS] excp_pc,
  input  logic            bj_ena,
  input  logic [`REG_BUS] new_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [`REG_BUS] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  output logic            inst_valid,
  input  logic            id_ready,
  output logic [`REG_BUS] inst_pc,
  output logic [31:0]     inst,
  output logic [`EXCP_BUS] if_excp
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [`REG_BUS] fpc;
  logic [`REG_BUS] fpc_nxt;
  logic [`REG_BUS] tgt;
  logic            redir;
  logic            misal;
  logic            misal_nxt;
  logic            lat_rsp;
  logic            lat_nop;
  logic            req_valid_nxt;
  logic            inst_valid_nxt;

  assign redir = excp_jmp_ena | bj_ena;
  assign tgt   = excp_jmp_ena ? excp_pc : new_pc;

  assign mem_req_addr = fpc;

`ifdef IF_MISAL_EXCP_EN
  assign misal     = fpc[1:0] != 2'b00;
  assign misal_nxt = fpc_nxt[1:0] != 2'b00;
`else
  assign misal     = 1'b0;
  assign misal_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      fpc   <= `PC_START;
    end else begin
      state <= state_nxt;
      fpc   <= fpc_nxt;
    end
  end

  // A misaligned fetch never issues a request,
  // so a redirect there needs no stale-drop.
  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    lat_rsp   = 1'b0;
    lat_nop   = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (redir) begin
          fpc_nxt = tgt;
          if (mem_req_ready && !misal)
            state_nxt = S_DROP;
        end else if (misal) begin
          state_nxt = S_HOLD;
          lat_nop   = 1'b1;
        end else if (mem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redir) begin
          fpc_nxt   = tgt;
          state_nxt = mem_rsp_valid ? S_REQ : S_DROP;
        end else if (mem_rsp_valid) begin
          state_nxt = S_HOLD;
          lat_rsp   = 1'b1;
        end
      end
      S_DROP: begin
        if (redir)
          fpc_nxt = tgt;
        if (mem_rsp_valid)
          state_nxt = S_REQ;
      end
      S_HOLD: begin
        if (redir) begin
          fpc_nxt   = tgt;
          state_nxt = S_REQ;
        end else if (id_ready) begin
          fpc_nxt   = fpc + 64'd4;
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state.
  always_comb begin
    req_valid_nxt  = (state_nxt == S_REQ) && !misal_nxt;
    inst_valid_nxt = (state_nxt == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      inst_valid    <= 1'b0;
      inst          <= 32'h0;
      inst_pc       <= '0;
    end else begin
      mem_req_valid <= req_valid_nxt;
      inst_valid    <= inst_valid_nxt;
      if (lat_rsp) begin
        inst    <= mem_rsp_data;
        inst_pc <= fpc;
      end else if (lat_nop) begin
        inst    <= NOP;
        inst_pc <= fpc;
      end
    end
  end

`ifdef IF_MISAL_EXCP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if_excp <= '0;
    end else if (lat_rsp) begin
      if_excp <= '0;
    end else if (lat_nop) begin
      if_excp <= '0;
      if_excp[`EXCP_INST_MISAL] <= 1'b1;
    end
  end
`else
  assign if_excp = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: scoreboard bench for if_fetch_ctrl.
// Memory model answers after a programmable latency.

module tb_if_fetch_ctrl;

  localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] T1 = 64'h0000_0000_8000_0100;
  localparam logic [63:0] T2 = 64'h0000_0000_8000_0200;
  localparam logic [63:0] T3 = 64'h0000_0000_8000_0300;
  localparam logic [63:0] T4 = 64'h0000_0000_8000_0400;
  localparam logic [63:0] WR = 64'hffff_ffff_ffff_fffc;
  localparam logic [63:0] MS = 64'h0000_0000_8000_0102;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp_jmp_ena;
  logic [63:0] excp_pc;
  logic        bj_ena;
  logic [63:0] new_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        inst_valid;
  logic        id_ready;
  logic [63:0] inst_pc;
  logic [31:0] inst;
  logic [3:0]  if_excp;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic [63:0] exp_addr_q[$];
  exp_t        exp_inst_q[$];
  exp_t        e;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  int last_acc = -1;
  bit gap_en = 1'b0;

  if_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .excp_jmp_ena (excp_jmp_ena),
    .excp_pc      (excp_pc),
    .bj_ena       (bj_ena),
    .new_pc       (new_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr (mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .inst_valid   (inst_valid),
    .id_ready     (id_ready),
    .inst_pc      (inst_pc),
    .inst         (inst),
    .if_excp      (if_excp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [63:0] pc);
    exp_t x;
    x.pc  = pc;
    x.ins = mdata(pc);
    exp_inst_q.push_back(x);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!inst_valid && n < 50);
    chk(tag, 64'(inst_valid), 64'd1);
  endtask

  task automatic wait_inst_drain(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (exp_inst_q.size() != 0 && n < 50);
    chk(tag, 64'(exp_inst_q.size()), 64'd0);
  endtask

  task automatic wait_addr_drain(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (exp_addr_q.size() != 0 && n < 50);
    chk(tag, 64'(exp_addr_q.size()), 64'd0);
  endtask

  // memory: response lat cycles after acceptance
  initial begin : mem_model
    bit          hs;
    bit          pend;
    int          cnt;
    logic [63:0] ha;
    logic [63:0] pa;
    pend = 1'b0;
    cnt = 0;
    pa = '0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready && !rst;
      ha = mem_req_addr;
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (hs) begin
          pend = 1'b1;
          cnt = lat;
          pa = ha;
        end
        if (pend) begin
          if (cnt <= 1) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = mdata(pa);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        if (exp_addr_q.size() == 0)
          chk("req_unexp", 64'(exp_addr_q.size()), 64'd1);
        else
          chk("req_addr", mem_req_addr, exp_addr_q.pop_front());
      end
      if (inst_valid && id_ready && !excp_jmp_ena && !bj_ena) begin
        if (exp_inst_q.size() == 0) begin
          chk("inst_unexp", 64'(exp_inst_q.size()), 64'd1);
        end else begin
          e = exp_inst_q.pop_front();
          chk("inst_pc", inst_pc, e.pc);
          chk("inst", 64'(inst), 64'(e.ins));
          chk("if_excp", 64'(if_excp), 64'd0);
        end
        if (gap_en && last_acc >= 0)
          chk("ipc_gap", 64'(cyc - last_acc), 64'd3);
        last_acc = cyc;
      end
    end
  end

  initial begin
    rst = 1'b1;
    excp_jmp_ena = 1'b0;
    excp_pc = '0;
    bj_ena = 1'b0;
    new_pc = '0;
    mem_req_ready = 1'b0;
    id_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst", 64'(inst), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_if_excp", 64'(if_excp), 64'd0);
    chk("rst_addr", mem_req_addr, A0);

    // streaming, 1-cycle memory, decode always ready
    for (int i = 0; i < 4; i++)
      exp_addr_q.push_back(A0 + 64'(4 * i));
    for (int i = 0; i < 3; i++)
      push_inst(A0 + 64'(4 * i));
    mem_req_ready = 1'b1;
    id_ready = 1'b1;
    gap_en = 1'b1;
    rst = 1'b0;
    wait_inst_drain("s1_drain");
    gap_en = 1'b0;
    id_ready = 1'b0;

    // decode stall in HOLD
    wait_valid("s2_hold");
    chk("s2_pc", inst_pc, A0 + 64'd12);
    chk("s2_inst", 64'(inst), 64'(mdata(A0 + 64'd12)));
    repeat (5) begin
      tick();
      chk("s2_noreq", 64'(mem_req_valid), 64'd0);
      chk("s2_pc_stable", inst_pc, A0 + 64'd12);
      chk("s2_inst_stable", 64'(inst), 64'(mdata(A0 + 64'd12)));
    end
    push_inst(A0 + 64'd12);
    exp_addr_q.push_back(A0 + 64'd16);
    lat = 3;
    id_ready = 1'b1;

    // branch while waiting, stale response dropped
    wait_addr_drain("s3_acc");
    exp_addr_q.push_back(T1);
    bj_ena = 1'b1;
    new_pc = T1;
    tick();
    bj_ena = 1'b0;
    chk("s3_drop_noreq1", 64'(mem_req_valid), 64'd0);
    tick();
    chk("s3_drop_noreq2", 64'(mem_req_valid), 64'd0);
    chk("s3_no_inst", 64'(inst_valid), 64'd0);
    tick();
    chk("s3_req_valid", 64'(mem_req_valid), 64'd1);
    chk("s3_req_addr", mem_req_addr, T1);
    chk("s3_no_inst2", 64'(inst_valid), 64'd0);
    lat = 1;
    id_ready = 1'b0;

    // trap and branch together in HOLD
    wait_valid("s4_hold");
    chk("s4_pc", inst_pc, T1);
    chk("s4_inst", 64'(inst), 64'(mdata(T1)));
    excp_jmp_ena = 1'b1;
    excp_pc = T2;
    bj_ena = 1'b1;
    new_pc = T3;
    id_ready = 1'b1;
    mem_req_ready = 1'b0;
    tick();
    excp_jmp_ena = 1'b0;
    id_ready = 1'b0;
    chk("s4_inst_drop", 64'(inst_valid), 64'd0);
    chk("s4_req_valid", 64'(mem_req_valid), 64'd1);
    chk("s4_req_addr", mem_req_addr, T2);

    // redirect in REQ before acceptance
    new_pc = T4;
    tick();
    bj_ena = 1'b0;
    chk("s5_req_valid", 64'(mem_req_valid), 64'd1);
    chk("s5_req_addr", mem_req_addr, T4);
    exp_addr_q.push_back(T4);
    exp_addr_q.push_back(T4 + 64'd4);
    push_inst(T4);
    id_ready = 1'b1;
    mem_req_ready = 1'b1;
    wait_inst_drain("s5_drain");
    id_ready = 1'b0;
    wait_valid("s5_hold");
    chk("s5_next_pc", inst_pc, T4 + 64'd4);

    // PC wraps past 2^64
    exp_addr_q.push_back(WR);
    exp_addr_q.push_back(64'd0);
    push_inst(WR);
    bj_ena = 1'b1;
    new_pc = WR;
    id_ready = 1'b1;
    tick();
    bj_ena = 1'b0;
    wait_inst_drain("wrap_drain");
    id_ready = 1'b0;
    wait_valid("wrap_hold");
    chk("wrap_pc", inst_pc, 64'd0);
    chk("wrap_inst", 64'(inst), 64'(mdata(64'd0)));

`ifdef IF_MISAL_EXCP_EN
    bj_ena = 1'b1;
    new_pc = MS;
    tick();
    bj_ena = 1'b0;
    chk("mis_noreq", 64'(mem_req_valid), 64'd0);
    tick();
    chk("mis_valid", 64'(inst_valid), 64'd1);
    chk("mis_inst", 64'(inst), 64'h13);
    chk("mis_pc", inst_pc, MS);
    chk("mis_excp", 64'(if_excp[0]), 64'd1);
    repeat (3) tick();
    chk("mis_noreq2", 64'(mem_req_valid), 64'd0);
`endif

    repeat (3) tick();
    chk("addr_q_left", 64'(exp_addr_q.size()), 64'd0);
    chk("inst_q_left", 64'(exp_inst_q.size()), 64'd0);

    // reset while holding an instruction
    rst = 1'b1;
    tick();
    chk("rst2_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst2_req_valid", 64'(mem_req_valid), 64'd0);
    chk("rst2_addr", mem_req_addr, A0);
    chk("rst2_inst", 64'(inst), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
